// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pkg
// Brief    : Shared encodings for the HI/LO multiply/divide scheduler:
//            md_op function codes, FSM state type, default operand width.
// Revision : 1.0 - initial release
// ============================================================================
package hilo_pkg;

  localparam int HILO_WIDTH = 32;

  // md_op is the instruction func[1:0] field
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_core
// Brief    : Unsigned iterative datapath. One shift-add multiply step or one
//            restoring subtract-shift divide step per 'step' strobe on a
//            2*WIDTH accumulator. After WIDTH steps acc_hi/acc_lo hold the
//            product (upper/lower) or remainder/quotient.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  // acc = {partial product / remainder, multiplier / quotient bits}
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  // multiplicand or divisor, held for the whole operation
  logic [WIDTH-1:0]   operand;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;

  // One iteration: shift-add for multiply, trial-subtract for divide
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    trial     = rem_shift - {1'b0, operand};
    acc_next  = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // borrow out (trial MSB) means the divisor did not fit: keep remainder
      if (!trial[WIDTH]) begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Accumulator and operand registers
  always_ff @(posedge clock) begin
    if (reset) begin
      acc     <= '0;
      operand <= '0;
    end else if (load) begin
      acc     <= {{WIDTH{1'b0}}, op_a};
      operand <= op_b;
    end else if (step) begin
      acc     <= acc_next;
    end
  end

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Brief    : HI/LO multiply/divide scheduler. Accepts mult/div and mt/mf
//            requests, runs the iterative core for WIDTH steps, applies sign
//            correction and owns HI/LO. Stalls requesters while busy.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             mfhi,
  input  logic             mflo,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data,
  output logic             busy,
  output logic             stall,
  output logic             div_zero
);

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   count;
  logic               op_div;
  logic               neg_res;   // product / quotient must be negated
  logic               rs_neg;    // remainder takes the dividend sign
  logic               core_load;
  logic               core_step;
  logic               start_signed;
  logic               start_div;
  logic               start_div_zero;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   core_hi;
  logic [WIDTH-1:0]   core_lo;
  logic [2*WIDTH-1:0] mag_prod;
  logic [2*WIDTH-1:0] fixed_prod;

  assign start_signed   = op_is_signed(md_op);
  assign start_div      = op_is_div(md_op);
  assign start_div_zero = start_div && (rt_data == '0);
  // the core works on magnitudes; signs are re-applied in FIX
  assign rs_mag = (start_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign rt_mag = (start_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  assign mag_prod   = {core_hi, core_lo};
  assign fixed_prod = neg_res ? -mag_prod : mag_prod;

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (op_div),
    .op_a   (rs_mag),
    .op_b   (rt_mag),
    .acc_hi (core_hi),
    .acc_lo (core_lo)
  );

  // Next-state and core strobes
  always_comb begin
    next_state = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state)
      IDLE: begin
        // divide by zero completes immediately without entering CALC
        if (md_start && !flush && !start_div_zero) begin
          next_state = CALC;
          core_load  = 1'b1;
        end
      end
      CALC: begin
        if (flush) begin
          next_state = IDLE;
        end else begin
          core_step = 1'b1;
          if (count == LAST_STEP) begin
            next_state = FIX;
          end
        end
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, step counter, operation flags and HI/LO ownership
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      rs_neg   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= next_state;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            // a start with flush is dropped; mt* requests lose to md_start
            if (!flush) begin
              if (start_div_zero) begin
                lo       <= '1;
                hi       <= rs_data;
                div_zero <= 1'b1;
              end else begin
                count   <= '0;
                op_div  <= start_div;
                neg_res <= start_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                rs_neg  <= start_signed && rs_data[WIDTH-1];
              end
            end
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        CALC: begin
          if (!flush) count <= count + 1'b1;
        end
        FIX: begin
          if (!flush) begin
            if (op_div) begin
              lo <= neg_res ? -core_lo : core_lo;
              hi <= rs_neg  ? -core_hi : core_hi;
            end else begin
              hi <= fixed_prod[2*WIDTH-1:WIDTH];
              lo <= fixed_prod[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign stall   = busy && (md_start || mthi || mtlo || mfhi || mflo);
  assign mf_data = mfhi ? hi : (mflo ? lo : '0);

endmodule
`default_nettype wire
